line_buffer_ctrl: RTL and testbench
===================================

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640: pixels per image row.
REQ-002 SHALL have parameter HEIGHT, default 480: rows per frame.
REQ-003 SHALL have parameter ROWS, fixed at 3: number of circular row buffers.
REQ-004 SHALL have parameter COL_BITS, default 10, and ROW_BITS, default 9: counter widths.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  frame start request; sampled only in IDLE.
REQ-008 in_valid  in  1  upstream pixel valid.
REQ-009 out_ready  in  1  downstream can accept a window.
REQ-010 in_ready  out  1  pixel accepted this cycle when in_valid && in_ready ("accept").
REQ-011 wr_en  out  1  combinational, equals accept.
REQ-012 wr_row  out  2  buffer index to write, range 0..2.
REQ-013 wr_addr  out  COL_BITS  column to write (current col).
REQ-014 rd_col  out  COL_BITS  registered column of the emitted window.
REQ-015 row_top, row_mid, row_bot  out  2 each  registered buffer indices, oldest to newest.
REQ-016 win_valid  out  1  registered; 3x3 column data available at rd_col.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel of the frame.

Function
REQ-018 FSM SHALL have states IDLE, FILL, STREAM, DONE.
- IDLE->FILL on start.
- FILL->STREAM when the accept completes row 1 (second row).
- STREAM->DONE when the accept completes row HEIGHT-1.
- DONE->IDLE unconditionally after one cycle.
REQ-019 in_ready SHALL be 0 in IDLE and DONE, 1 in FILL, and equal out_ready in STREAM.
REQ-020 On entering FILL, col, row_cnt and wr_row SHALL clear to 0.
REQ-021 On accept, col SHALL increment. At col==WIDTH-1 it SHALL wrap to 0, row_cnt SHALL increment, and wr_row SHALL advance cyclically (2 wraps to 0).
REQ-022 All cyclic index arithmetic SHALL be modulo ROWS with no out-of-range intermediate value ever driven.
REQ-023 On an accept in STREAM, the next cycle SHALL show:
- win_valid=1, rd_col=col at the time of accept;
- row_bot=wr_row, row_mid=(wr_row+2) mod 3, row_top=(wr_row+1) mod 3.
Otherwise win_valid=0 and the other registered outputs hold their values.
REQ-024 Latency from accept to win_valid SHALL be exactly 1 cycle.
REQ-025 No window SHALL be emitted for pixels accepted in FILL.
REQ-026 frame_done SHALL be asserted during the single DONE cycle.
REQ-027 start outside IDLE SHALL be ignored. start together with in_valid in IDLE SHALL NOT accept a pixel.
REQ-028 If in_valid=1 and out_ready=0 in STREAM, no counter or output (other than win_valid=0) SHALL change.

Reset
REQ-029 While rst=1, the following SHALL be forced asynchronously:
- state=IDLE;
- col, row_cnt, wr_row, rd_col = 0;
- row_top=0, row_mid=0, row_bot=0;
- win_valid, frame_done, in_ready, wr_en = 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame. A new start is required after release.

Configuration
REQ-031 Macro LINE_BUFFER_BORDER_EN, when defined, SHALL add output win_border (1 bit, registered with win_valid). It is 1 when the emitted rd_col is 0 or WIDTH-1, or when the window's bottom row is row 2 or row HEIGHT-1.
REQ-032 Without LINE_BUFFER_BORDER_EN, the win_border port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4, HEIGHT=4)
REQ-033 rst pulse mid-STREAM at row 2 col 1 -> all outputs 0 and state IDLE immediately. A pixel offered after release is not accepted until start.
REQ-034 start, then 8 pixels with in_valid=1 -> win_valid stays 0, wr_row sequence 0,0,0,0,1,1,1,1, then STREAM is entered.
REQ-035 Pixel 9 (row 2, col 0) -> next cycle win_valid=1, rd_col=0, row_top=0, row_mid=1, row_bot=2.
REQ-036 Pixel 13 (row 3, col 0) -> wr_row wraps to 0; next cycle row_top=1, row_mid=2, row_bot=0.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 in STREAM -> in_ready=0, col frozen, win_valid=0 throughout.
REQ-038 Pixel 16 accepted -> win_valid next cycle, frame_done pulses exactly 1 cycle, state returns to IDLE, and a start asserted during DONE is ignored.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
// ----------------
// Controller for a 3-row circular line buffer feeding a 3x3 sliding window.
// Pixels stream in row by row. The first two rows of a frame only fill the
// buffers. From the third row onward every accepted pixel produces one
// window column, one cycle later, built from the three buffered rows.
//
// Optional feature: define LINE_BUFFER_BORDER_EN to add the win_border
// output, which flags windows touching the image edge.
//
// Ports:
//   clk, rst       single clock, asynchronous active-high reset
//   start          frame start request (honoured only when idle)
//   in_valid       upstream pixel valid
//   out_ready      downstream can take a window
//   in_ready       pixel accepted when in_valid && in_ready
//   wr_en          buffer write strobe (equals accept)
//   wr_row         buffer index being written (0..2)
//   wr_addr        column being written
//   rd_col         column of the emitted window (registered)
//   row_top/mid/bot buffer indices of the window rows, oldest to newest
//   win_valid      window available at rd_col (registered)
//   frame_done     high for the single cycle after the frame's last pixel
//   win_border     (optional) window lies on the image border
module line_buffer_ctrl #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int ROWS     = 3,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic                in_ready,
    output logic                wr_en,
    output logic [1:0]          wr_row,
    output logic [COL_BITS-1:0] wr_addr,
    output logic [COL_BITS-1:0] rd_col,
    output logic [1:0]          row_top,
    output logic [1:0]          row_mid,
    output logic [1:0]          row_bot,
    output logic                win_valid,
`ifdef LINE_BUFFER_BORDER_EN
    output logic                frame_done,
    output logic                win_border
`else
    output logic                frame_done
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t state, next_state;

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row_cnt;
    logic                accept;
    logic                col_last;
    logic                row_last;
    logic                fill_last;

    // Cyclic buffer index helpers; they never produce a value >= ROWS.
    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'(ROWS - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [1:0] idx_dec(input logic [1:0] idx);
        return (idx == 2'd0) ? 2'(ROWS - 1) : idx - 2'd1;
    endfunction

    assign col_last  = (col == COL_BITS'(WIDTH - 1));
    assign row_last  = (row_cnt == ROW_BITS'(HEIGHT - 1));
    assign fill_last = (row_cnt == ROW_BITS'(1));

    assign accept     = in_valid && in_ready;
    assign wr_en      = accept;
    assign wr_addr    = col;
    assign frame_done = (state == DONE);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and in_ready. Transitions use in_valid gated by the
    // state's own readiness rather than accept, so in_ready never feeds
    // back into this block.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && col_last && fill_last) next_state = STREAM;
            end
            STREAM: begin
                in_ready = out_ready;
                if (in_valid && out_ready && col_last && row_last) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write-side position: cleared when a frame starts, advanced on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row_cnt <= '0;
            wr_row  <= 2'd0;
        end else if (state == IDLE && start) begin
            col     <= '0;
            row_cnt <= '0;
            wr_row  <= 2'd0;
        end else if (accept) begin
            if (col_last) begin
                col     <= '0;
                row_cnt <= row_cnt + ROW_BITS'(1);
                wr_row  <= idx_inc(wr_row);
            end else begin
                col <= col + COL_BITS'(1);
            end
        end
    end

    // Window outputs: one cycle after a streaming accept, the newest row is
    // the one just written and the two older rows precede it cyclically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            rd_col    <= '0;
            row_top   <= 2'd0;
            row_mid   <= 2'd0;
            row_bot   <= 2'd0;
        end else begin
            win_valid <= 1'b0;
            if (accept && state == STREAM) begin
                win_valid <= 1'b1;
                rd_col    <= col;
                row_bot   <= wr_row;
                row_mid   <= idx_dec(wr_row);
                row_top   <= idx_inc(wr_row);
            end
        end
    end

`ifdef LINE_BUFFER_BORDER_EN
    // Border flag travels with the window it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_border <= 1'b0;
        end else if (accept && state == STREAM) begin
            win_border <= (col == '0) || col_last ||
                          (row_cnt == ROW_BITS'(2)) || row_last;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed testbench for line_buffer_ctrl at WIDTH=4, HEIGHT=4.
module tb_line_buffer_ctrl;

    localparam int WIDTH    = 4;
    localparam int HEIGHT   = 4;
    localparam int COL_BITS = 10;
    localparam int ROW_BITS = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic                out_ready;
    logic                in_ready;
    logic                wr_en;
    logic [1:0]          wr_row;
    logic [COL_BITS-1:0] wr_addr;
    logic [COL_BITS-1:0] rd_col;
    logic [1:0]          row_top;
    logic [1:0]          row_mid;
    logic [1:0]          row_bot;
    logic                win_valid;
    logic                frame_done;
`ifdef LINE_BUFFER_BORDER_EN
    logic                win_border;
`endif

    int compared   = 0;
    int mismatched = 0;

    line_buffer_ctrl #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ROWS    (3),
        .COL_BITS(COL_BITS),
        .ROW_BITS(ROW_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_addr   (wr_addr),
        .rd_col    (rd_col),
        .row_top   (row_top),
        .row_mid   (row_mid),
        .row_bot   (row_bot),
        .win_valid (win_valid),
`ifdef LINE_BUFFER_BORDER_EN
        .frame_done(frame_done),
        .win_border(win_border)
`else
        .frame_done(frame_done)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic s, input logic v, input logic r);
        start     = s;
        in_valid  = v;
        out_ready = r;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel, check it is written where expected, then clock it in.
    task automatic pushPixel(input string tag, input logic [1:0] exp_row,
                             input logic [COL_BITS-1:0] exp_col);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput({tag, " wr_en"},   32'(wr_en),   32'd1);
        checkOutput({tag, " wr_row"},  32'(wr_row),  32'(exp_row));
        checkOutput({tag, " wr_addr"}, 32'(wr_addr), 32'(exp_col));
        tick();
    endtask

    // Check a window emitted one cycle after a streaming accept.
    task automatic checkWindow(input string tag, input logic [COL_BITS-1:0] c,
                               input logic [1:0] t, input logic [1:0] m,
                               input logic [1:0] b);
        checkOutput({tag, " win_valid"}, 32'(win_valid), 32'd1);
        checkOutput({tag, " rd_col"},    32'(rd_col),    32'(c));
        checkOutput({tag, " row_top"},   32'(row_top),   32'(t));
        checkOutput({tag, " row_mid"},   32'(row_mid),   32'(m));
        checkOutput({tag, " row_bot"},   32'(row_bot),   32'(b));
    endtask

    initial begin
        logic [1:0] fill_rows [8];
        fill_rows = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

        // Reset state, with a pixel offered that must not be taken.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #3;
        checkOutput("rst in_ready",   32'(in_ready),   32'd0);
        checkOutput("rst wr_en",      32'(wr_en),      32'd0);
        checkOutput("rst win_valid",  32'(win_valid),  32'd0);
        checkOutput("rst frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst rd_col",     32'(rd_col),     32'd0);
        checkOutput("rst wr_row",     32'(wr_row),     32'd0);
        checkOutput("rst wr_addr",    32'(wr_addr),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Idle: a pixel without start is refused; start with a pixel is too.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("idle in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("idle start wr_en", 32'(wr_en), 32'd0);
        tick();

        // Fill: two rows land in buffers 0 and 1, no windows emitted.
        $display("[TB] filling first two rows");
        for (int i = 0; i < 8; i++) begin
            pushPixel($sformatf("fill%0d", i + 1), fill_rows[i], COL_BITS'(i % WIDTH));
            checkOutput($sformatf("fill%0d win_valid", i + 1), 32'(win_valid), 32'd0);
        end

        // Pixel 9: first window, row 2 col 0.
        pushPixel("px9", 2'd2, COL_BITS'(0));
        checkWindow("px9", COL_BITS'(0), 2'd0, 2'd1, 2'd2);
        pushPixel("px10", 2'd2, COL_BITS'(1));
        checkWindow("px10", COL_BITS'(1), 2'd0, 2'd1, 2'd2);

        // Bubble: no pixel, window drops and registered outputs hold.
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bubble win_valid", 32'(win_valid), 32'd0);
        checkOutput("bubble rd_col",    32'(rd_col),    32'd1);

        pushPixel("px11", 2'd2, COL_BITS'(2));
        pushPixel("px12", 2'd2, COL_BITS'(3));
        checkWindow("px12", COL_BITS'(3), 2'd0, 2'd1, 2'd2);

        // Pixel 13: row 3 wraps the write buffer back to 0.
        pushPixel("px13", 2'd0, COL_BITS'(0));
        checkWindow("px13", COL_BITS'(0), 2'd1, 2'd2, 2'd0);

        // Downstream stall for three cycles: nothing advances.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall%0d wr_en", i),    32'(wr_en),    32'd0);
            tick();
            checkOutput($sformatf("stall%0d wr_addr", i),   32'(wr_addr),   32'd1);
            checkOutput($sformatf("stall%0d win_valid", i), 32'(win_valid), 32'd0);
            checkOutput($sformatf("stall%0d rd_col", i),    32'(rd_col),    32'd0);
            checkOutput($sformatf("stall%0d row_bot", i),   32'(row_bot),   32'd0);
        end

        pushPixel("px14", 2'd0, COL_BITS'(1));
        checkWindow("px14", COL_BITS'(1), 2'd1, 2'd2, 2'd0);
        pushPixel("px15", 2'd0, COL_BITS'(2));
        checkOutput("px15 frame_done", 32'(frame_done), 32'd0);

        // Last pixel: window plus frame_done; start during DONE is ignored.
        pushPixel("px16", 2'd0, COL_BITS'(3));
        checkWindow("px16", COL_BITS'(3), 2'd1, 2'd2, 2'd0);
        checkOutput("done frame_done", 32'(frame_done), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("done in_ready", 32'(in_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("after done frame_done", 32'(frame_done), 32'd0);
        checkOutput("after done win_valid",  32'(win_valid),  32'd0);
        checkOutput("after done in_ready",   32'(in_ready),   32'd0);
        tick();
        checkOutput("ignored start in_ready", 32'(in_ready), 32'd0);

        // Second frame, reset at row 2 col 1 in the middle of a cycle.
        $display("[TB] second frame with mid-stream reset");
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            pushPixel($sformatf("f2 fill%0d", i + 1), fill_rows[i], COL_BITS'(i % WIDTH));
        end
        pushPixel("f2 px9", 2'd2, COL_BITS'(0));
        applyStimulus(1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid rst in_ready",  32'(in_ready),  32'd0);
        checkOutput("mid rst wr_en",     32'(wr_en),     32'd0);
        checkOutput("mid rst win_valid", 32'(win_valid), 32'd0);
        checkOutput("mid rst rd_col",    32'(rd_col),    32'd0);
        checkOutput("mid rst row_top",   32'(row_top),   32'd0);
        checkOutput("mid rst row_mid",   32'(row_mid),   32'd0);
        checkOutput("mid rst row_bot",   32'(row_bot),   32'd0);
        checkOutput("mid rst wr_row",    32'(wr_row),    32'd0);
        checkOutput("mid rst wr_addr",   32'(wr_addr),   32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("post rst%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart in_ready", 32'(in_ready), 32'd1);
        checkOutput("restart wr_row",   32'(wr_row),   32'd0);
        checkOutput("restart wr_addr",  32'(wr_addr),  32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
